// File: rtl/i2s_transmit_param.sv
// Parametrised I2S / left-justified stereo transmitter slaved to external SCK/WS,
// with a stereo frame FIFO on a valid/ready input and underrun/framing reporting.
module i2s_transmit_param #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned MODE_LJ    = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          sck_i,
  input  logic                          ws_i,
  input  logic [2*DATA_W-1:0]           s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic                          sd_o,
  output logic                          active_o,
  output logic                          underrun_o,
  output logic                          frame_err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned FRAME_W = 2 * DATA_W;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned POS_W   = 6;
  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [2:0]         sck_sync_q;   // [0],[1] synchroniser, [2] history
  logic [1:0]         ws_sync_q;
  logic               ws_q, ws_d;   // WS seen at the previous SCK fall
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               err_arm_q, err_arm_d;
  logic               active_q, active_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               sd_q, sd_d;
  logic               und_q, und_d;
  logic               ferr_q, ferr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ready_q, ready_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];

  logic               sck_fall, ws_now, ws_chg, left_start;
  logic               push, pop, activate, in_range;
  logic [DATA_W-1:0]  word, word_sh;
  logic [POS_W-1:0]   shamt;

  assign sck_fall   = sck_sync_q[2] & ~sck_sync_q[1];
  assign ws_now     = ws_sync_q[1];
  assign ws_chg     = sck_fall & (ws_now != ws_q);
  assign left_start = ws_chg & ~ws_now;

  // Synchronisers for the external bit clock and word select
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck_i};
      ws_sync_q  <= {ws_sync_q[0], ws_i};
    end
  end

  // Next-state: slot tracking, frame fetch, serial bit selection, FIFO bookkeeping
  always_comb begin
    ws_d      = ws_q;
    pos_d     = pos_q;
    err_arm_d = err_arm_q;
    active_d  = active_q;
    frame_d   = frame_q;
    sd_d      = sd_q;
    und_d     = 1'b0;
    ferr_d    = 1'b0;
    pop       = 1'b0;
    activate  = 1'b0;
    push      = s_valid_i & ready_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;

    if (left_start) begin
      if (!active_q) begin
        if (enable_i && (level_q != '0)) begin
          active_d = 1'b1;
          activate = 1'b1;
          pop      = 1'b1;
        end
      end else if (!enable_i) begin
        active_d = 1'b0;
      end else if (level_q != '0) begin
        pop = 1'b1;
      end else begin
        und_d = 1'b1;
      end
    end

    // The popped frame feeds the serialiser directly so the first bit is not stale
    if (pop) begin
      frame_d = mem[rd_ptr_q];
    end else if (und_d) begin
      frame_d = '0;
    end

    if (sck_fall) begin
      ws_d  = ws_now;
      pos_d = ws_chg ? '0 : ((pos_q == POS_MAX) ? POS_MAX : pos_q + POS_W'(1));
    end

    // First slot boundary after reset or activation has no trustworthy slot length
    if (ws_chg) begin
      ferr_d    = err_arm_q && ((7'(pos_q) + 7'd1) != 7'(SLOT_W));
      err_arm_d = ~activate;
    end

    word     = ws_now ? frame_d[DATA_W-1:0] : frame_d[FRAME_W-1:DATA_W];
    shamt    = (MODE_LJ != 0) ? pos_d : pos_d - POS_W'(1);
    word_sh  = word << shamt;
    in_range = (MODE_LJ != 0) ? (7'(pos_d) < 7'(DATA_W))
                              : ((pos_d != '0) && (7'(pos_d) <= 7'(DATA_W)));
    if (sck_fall) begin
      sd_d = active_d & in_range & word_sh[DATA_W-1];
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LW'(FIFO_DEPTH));
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ws_q      <= 1'b0;
      pos_q     <= '0;
      err_arm_q <= 1'b0;
      active_q  <= 1'b0;
      frame_q   <= '0;
      sd_q      <= 1'b0;
      und_q     <= 1'b0;
      ferr_q    <= 1'b0;
      level_q   <= '0;
      ready_q   <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      ws_q      <= ws_d;
      pos_q     <= pos_d;
      err_arm_q <= err_arm_d;
      active_q  <= active_d;
      frame_q   <= frame_d;
      sd_q      <= sd_d;
      und_q     <= und_d;
      ferr_q    <= ferr_d;
      level_q   <= level_d;
      ready_q   <= ready_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Frame storage
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= s_data_i;
  end

  assign s_ready_o    = ready_q;
  assign sd_o         = sd_q;
  assign active_o     = active_q;
  assign underrun_o   = und_q;
  assign frame_err_o  = ferr_q;
  assign fifo_level_o = level_q;

endmodule
